// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares one UART byte transmitter between NUM_REQ byte sources. A source
// owns the transmitter for a whole message (grant until its done pulse, a
// req drop, or a watchdog revoke). Owners are chosen round-robin, and the
// owner's valid/data reach the UART combinationally. Every release is
// followed by one GAP cycle before the next arbitration.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req            in   [NUM_REQ] request, held for the whole message
//   done           in   [NUM_REQ] 1-cycle message-complete pulse
//   src_valid      in   [NUM_REQ] per-source byte strobe
//   src_data       in   [8*NUM_REQ] per-source byte, source i at [8*i+7:8*i]
//   src_active     out  [NUM_REQ] owner sees uart_active, others see 1
//   uart_active    in   transmitter is shifting a byte
//   uart_valid     out  byte strobe to the transmitter
//   uart_data      out  [8] byte to the transmitter, 0 when uart_valid=0
//   grant          out  [NUM_REQ] registered one-hot owner, 0 when no owner
//   busy           out  high while a source owns the transmitter
//   timeout_pulse  out  1-cycle pulse when the watchdog revokes an owner
module serial_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ-1:0]     src_valid,
  input  logic [8*NUM_REQ-1:0]   src_data,
  output logic [NUM_REQ-1:0]     src_active,
  input  logic                   uart_active,
  output logic                   uart_valid,
  output logic [7:0]             uart_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_pulse
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [TW-1:0] timer;

  logic [PW-1:0] owner_idx;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] win_hi;
  logic [PW-1:0] win_lo;
  logic [PW-1:0] winner;
  logic          hi_any;
  logic [7:0]    owner_byte;
  logic          in_grant;
  logic          own_valid;
  logic          own_done;
  logic          own_req;
  logic          wd_hit;
  logic          leave;
  logic          wd_revoke;

  // Owner index and its byte, taken from the one-hot grant register.
  always_comb begin
    owner_idx  = '0;
    owner_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_idx  = PW'(i);
        owner_byte = src_data[8*i +: 8];
      end
    end
  end

  // Round-robin search: lowest requester at or above rr_ptr, otherwise
  // wrap around to the lowest requester overall.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = PW'(i);
      end
      if (req[i] && (PW'(i) >= rr_ptr)) begin
        win_hi = PW'(i);
        hi_any = 1'b1;
      end
    end
    winner = hi_any ? win_hi : win_lo;
  end

  assign in_grant  = (state == S_GRANT);
  assign own_valid = in_grant && |(src_valid & grant);
  assign own_done  = in_grant && |(done & grant);
  assign own_req   = |(req & grant);

  // Watchdog fires only on a cycle that is itself idle at the limit.
  assign wd_hit    = WD_EN && in_grant && !uart_active && !own_valid && (timer == TLIM);
  assign leave     = in_grant && (own_done || !own_req || wd_hit);
  // done and req drop take priority: the pulse flags a genuine revoke only.
  assign wd_revoke = wd_hit && !own_done && own_req;

  assign rr_next   = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;

  assign uart_valid = own_valid;
  assign uart_data  = own_valid ? owner_byte : 8'h00;
  assign src_active = in_grant ? (~grant | (grant & {NUM_REQ{uart_active}})) : '1;
  assign busy       = in_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant <= ONE << winner;
            state <= S_GRANT;
            timer <= '0;
          end
        end
        S_GRANT: begin
          if (leave) begin
            grant         <= '0;
            state         <= S_GAP;
            rr_ptr        <= rr_next;
            timeout_pulse <= wd_revoke;
          end else if (own_valid) begin
            timer <= '0;
          end else if (!uart_active && (timer != TMAX)) begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: directed scenarios followed by random
// multi-source traffic. A transaction-level reference model predicts the
// owner, grant, busy, src_active and timeout pulse for each cycle plus the
// byte stream the UART must see; a separate monitor pops and compares.
module tb_serial_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic [N-1:0]     src_valid;
  logic [8*N-1:0]   src_data;
  logic [N-1:0]     src_active;
  logic             uart_active;
  logic             uart_valid;
  logic [7:0]       uart_data;
  logic [N-1:0]     grant;
  logic             busy;
  logic             timeout_pulse;

  always #5 clock = ~clock;

  serial_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .done         (done),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_active   (src_active),
    .uart_active  (uart_active),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .grant        (grant),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] active;
    logic         busy;
    logic         tp;
    logic         valid;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: who owns the UART, whether we sit in the post-release
  // gap, where the next round-robin search starts, idle cycles of the owner.
  int   m_owner = -1;
  int   m_gap   = 0;
  int   m_next  = 0;
  int   m_idle  = 0;
  logic m_tp    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic rst_v, input logic [N-1:0] r, input logic [N-1:0] d,
                            input logic [N-1:0] v, input logic [8*N-1:0] dat, input logic ua);
    exp_t e;
    bit   idle_c;
    bit   wd;
    bit   fin;
    if (!rst_v) begin
      m_owner = -1; m_gap = 0; m_next = 0; m_idle = 0; m_tp = 1'b0;
    end
    e.grant  = '0;
    e.active = '1;
    e.busy   = 1'b0;
    e.valid  = 1'b0;
    e.tp     = m_tp;
    if (m_owner >= 0) begin
      e.grant[m_owner]  = 1'b1;
      e.active[m_owner] = ua;
      e.busy            = 1'b1;
      e.valid           = v[m_owner];
    end
    exp_q.push_back(e);
    if (e.valid) byte_q.push_back(dat[8*m_owner +: 8]);
    if (!rst_v) return;
    m_tp = 1'b0;
    if (m_owner >= 0) begin
      idle_c = !ua && !e.valid;
      wd     = (T > 0) && idle_c && (m_idle == T - 1);
      fin    = d[m_owner] || !r[m_owner] || wd;
      if (fin) begin
        m_tp    = wd && !d[m_owner] && r[m_owner];
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else if (e.valid) begin
        m_idle = 0;
      end else if (!ua) begin
        m_idle++;
      end
    end else if (m_gap > 0) begin
      m_gap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_next + k) % N]) begin
          m_owner = (m_next + k) % N;
          m_idle  = 0;
          break;
        end
      end
    end
  endtask

  task automatic drive(input logic rst_v, input logic [N-1:0] r, input logic [N-1:0] d,
                       input logic [N-1:0] v, input logic [8*N-1:0] dat, input logic ua);
    @(posedge clock);
    #1;
    reset_n     = rst_v;
    req         = r;
    done        = d;
    src_valid   = v;
    src_data    = dat;
    uart_active = ua;
    model_step(rst_v, r, d, v, dat, ua);
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] v,
                     input logic [7:0] b, input logic ua);
    drive(1'b1, r, d, v, {N{b}}, ua);
  endtask

  // Monitor: one expectation per cycle, bytes popped whenever the DUT strobes.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(mon_e.grant));
        chk("src_active", 32'(src_active), 32'(mon_e.active));
        chk("busy", 32'(busy), 32'(mon_e.busy));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(mon_e.tp));
        chk("uart_valid", 32'(uart_valid), 32'(mon_e.valid));
        if (uart_valid === 1'b1) begin
          if (byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL uart_byte: got %0h, expected no byte at %0t", uart_data, $time);
          end else begin
            chk("uart_byte", 32'(uart_data), 32'(byte_q.pop_front()));
          end
        end else begin
          chk("uart_data_idle", 32'(uart_data), 32'h0);
        end
      end
    end
  end

  logic [N-1:0] rr, dd, vv, want, stall;
  logic         ua_r;
  int           left[N];
  int           cnt[N];
  int           o;

  initial begin
    reset_n = 1'b0; req = '0; done = '0; src_valid = '0; src_data = '0; uart_active = 1'b0;
    want = '0; stall = '0;
    for (int i = 0; i < N; i++) begin left[i] = 0; cnt[i] = 0; end

    // Reset state, with requests pending that must be ignored
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    drive(1'b0, 4'b1111, '0, 4'b1111, 32'h12345678, 1'b1);
    drive(1'b1, '0, '0, '0, '0, 1'b0);

    // Source 0 sends 31 53 4C 4F, done on the last byte
    cyc(4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 8'h31, 1'b1);
    cyc(4'b0001, 4'b0000, 4'b0001, 8'h53, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 8'h4C, 1'b1);
    cyc(4'b0001, 4'b0001, 4'b0001, 8'h4F, 1'b0);
    repeat (3) cyc('0, '0, '0, 8'h00, 1'b0);

    // Sources 0 and 1 both requesting, 2-byte messages
    for (int c = 0; c < 30; c++) begin
      vv = '0; dd = '0;
      if (m_owner >= 0) begin
        vv[m_owner] = 1'b1;
        cnt[m_owner]++;
        if (cnt[m_owner] == 2) begin dd[m_owner] = 1'b1; cnt[m_owner] = 0; end
      end
      cyc(4'b0011, dd, vv, 8'($urandom), 1'b0);
    end
    repeat (3) cyc('0, '0, '0, 8'h00, 1'b0);

    // Owner 2 active while source 3 strobes AA and pulses done
    while (m_owner != 2) cyc(4'b0100, '0, '0, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++)
      drive(1'b1, 4'b1100, (k == 3) ? 4'b1000 : 4'b0000, (k % 2 == 0) ? 4'b1100 : 4'b1000,
            {8'hAA, 8'(8'h20 + k), 8'h00, 8'h00}, k[0]);
    drive(1'b1, 4'b0100, 4'b0100, 4'b0000, {8'hAA, 24'h0}, 1'b0);
    repeat (3) cyc('0, '0, '0, 8'h00, 1'b0);

    // Watchdog: owner 1 never sends while source 0 waits
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, '0, 1'b0);
    cyc(4'b0010, '0, '0, 8'h00, 1'b0);
    repeat (24) cyc(4'b0011, '0, '0, 8'h00, 1'b0);
    cyc(4'b0011, 4'b0001, 4'b0001, 8'h5A, 1'b0);
    repeat (3) cyc('0, '0, '0, 8'h00, 1'b0);

    // Owner drops req after 2 of 4 bytes
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, '0, 1'b0);
    cyc(4'b0001, '0, '0, 8'h00, 1'b0);
    cyc(4'b0001, '0, 4'b0001, 8'hA1, 1'b0);
    cyc(4'b0001, '0, 4'b0001, 8'hA2, 1'b0);
    cyc(4'b0000, '0, 4'b0000, 8'h00, 1'b0);
    cyc(4'b0000, '0, 4'b0001, 8'hA3, 1'b0);
    cyc(4'b0000, '0, 4'b0001, 8'hA4, 1'b0);
    repeat (2) cyc('0, '0, '0, 8'h00, 1'b0);

    // Reset mid-message while a byte is being strobed
    cyc(4'b0001, '0, '0, 8'h00, 1'b0);
    cyc(4'b0001, '0, 4'b0001, 8'hB1, 1'b1);
    drive(1'b0, 4'b0001, '0, 4'b0001, {N{8'hB2}}, 1'b1);
    drive(1'b0, 4'b0001, '0, 4'b0001, {N{8'hB3}}, 1'b0);
    drive(1'b1, 4'b0100, '0, '0, '0, 1'b0);
    cyc(4'b0100, '0, 4'b0100, 8'hC1, 1'b0);
    cyc(4'b0100, 4'b0100, 4'b0100, 8'hC2, 1'b0);
    repeat (3) cyc('0, '0, '0, 8'h00, 1'b0);

    // Random traffic from all sources, with noise from non-owners
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i]  = 1'b1;
          left[i]  = $urandom_range(1, 4);
          stall[i] = ($urandom_range(0, 5) == 0);
        end
      end
      rr   = want;
      o    = m_owner;
      vv   = N'($urandom);
      dd   = N'($urandom & $urandom & $urandom);
      ua_r = ($urandom_range(0, 2) == 0);
      if (o >= 0) begin
        vv[o] = 1'b0;
        dd[o] = 1'b0;
        if (stall[o]) begin
          ua_r = 1'b0;
          if ($urandom_range(0, 39) == 0) stall[o] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          vv[o] = 1'b1;
          left[o]--;
          if (left[o] <= 0) begin
            dd[o] = 1'b1;
            if ($urandom_range(0, 1) == 1) want[o] = 1'b0;
            else left[o] = $urandom_range(1, 4);
          end
        end
        if ($urandom_range(0, 29) == 0) begin
          rr[o]   = 1'b0;
          want[o] = 1'b0;
        end
      end
      drive(1'b1, rr, dd, vv, $urandom, ua_r);
    end
    repeat (4) cyc('0, '0, '0, 8'h00, 1'b0);

    @(negedge clock);
    #1;
    chk("bytes_outstanding", byte_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
